// File: rtl/ula_seq_pkg.sv
// Shared opcode, ULA operation and sequencer state encodings for ula_seq.
package ula_seq_pkg;

    localparam logic [3:0] OP_LDX  = 4'b1000;
    localparam logic [3:0] OP_LDY  = 4'b1001;
    localparam logic [3:0] OP_MVZX = 4'b1010;
    localparam logic [3:0] OP_MVZY = 4'b1011;
    localparam logic [3:0] OP_NOP  = 4'b1100;

    localparam logic [2:0] ULA_ADD = 3'b000;
    localparam logic [2:0] ULA_SUB = 3'b001;
    localparam logic [2:0] ULA_NEG = 3'b010;
    localparam logic [2:0] ULA_EQ  = 3'b011;
    localparam logic [2:0] ULA_GT  = 3'b100;
    localparam logic [2:0] ULA_LT  = 3'b101;
    localparam logic [2:0] ULA_AND = 3'b110;
    localparam logic [2:0] ULA_XOR = 3'b111;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        WB    = 2'd2
    } state_t;

endpackage

// File: rtl/ula_seq_decode.sv
// Combinational opcode decode for the ula_seq sequencer.
module ula_seq_decode
    import ula_seq_pkg::*;
(
    input  logic [3:0] op_i,
    output logic       is_alu_o,
    output logic       is_cmp_o,
    output logic       wr_x_o,
    output logic       wr_y_o,
    output logic       src_z_o,
    output logic       illegal_o
);

    always_comb begin
        is_alu_o  = ~op_i[3];
        is_cmp_o  = ~op_i[3] && (op_i[2:0] == ULA_EQ || op_i[2:0] == ULA_GT ||
                                 op_i[2:0] == ULA_LT);
        wr_x_o    = (op_i == OP_LDX) || (op_i == OP_MVZX);
        wr_y_o    = (op_i == OP_LDY) || (op_i == OP_MVZY);
        src_z_o   = (op_i == OP_MVZX) || (op_i == OP_MVZY);
        // 1101..1111 sit above NOP in the register-op space
        illegal_o = op_i[3] && (op_i[2:0] > OP_NOP[2:0]);
    end

endmodule

// File: rtl/ula_seq.sv
// Sequencer and operand/result registers in front of the 4-bit combinational ULA.
// Optional registered overflow flag output when ULA_SEQ_OVF_EN is defined.
module ula_seq
    import ula_seq_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] outx,
    output logic [DATA_W-1:0] outy,
    output logic [2:0]        tula,
    input  logic [DATA_W-1:0] outula,
    input  logic              status,
    output logic [DATA_W-1:0] z_out,
    output logic              flag,
    output logic              done,
    output logic              err
`ifdef ULA_SEQ_OVF_EN
    ,
    output logic              ovf
`endif
);

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] opd_q;
    logic [DATA_W-1:0] x_q, y_q, z_q;
    logic              f_q;
    logic [2:0]        tula_q;

    logic is_alu, is_cmp, wr_x, wr_y, src_z, illegal;

    ula_seq_decode u_decode (
        .op_i      (op_q),
        .is_alu_o  (is_alu),
        .is_cmp_o  (is_cmp),
        .wr_x_o    (wr_x),
        .wr_y_o    (wr_y),
        .src_z_o   (src_z),
        .illegal_o (illegal)
    );

    // done/err are decoded from WB so an async reset cancels them immediately
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (state_q)
            FETCH: begin
                instr_ready = ~rst;
                if (instr_valid) state_d = opcode[OP_W-1] ? WB : EXEC;
            end
            EXEC: state_d = WB;
            WB: begin
                done    = 1'b1;
                err     = illegal;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            op_q    <= '0;
            opd_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            f_q     <= 1'b0;
            tula_q  <= ULA_ADD;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH && instr_valid) begin
                op_q  <= opcode;
                opd_q <= operand;
                if (!opcode[OP_W-1]) tula_q <= opcode[2:0];
            end
            if (state_q == WB) begin
                if (is_alu) begin
                    if (is_cmp) f_q <= status;
                    else        z_q <= outula;
                end
                if (wr_x) x_q <= src_z ? z_q : opd_q;
                if (wr_y) y_q <= src_z ? z_q : opd_q;
            end
        end
    end

`ifdef ULA_SEQ_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == WB && is_alu) begin
            if (tula_q == ULA_ADD)
                ovf_q <= (x_q[DATA_W-1] == y_q[DATA_W-1]) && (outula[DATA_W-1] != x_q[DATA_W-1]);
            else if (tula_q == ULA_SUB)
                ovf_q <= (x_q[DATA_W-1] != y_q[DATA_W-1]) && (outula[DATA_W-1] != x_q[DATA_W-1]);
        end
    end

    assign ovf = ovf_q;
`endif

    assign outx  = x_q;
    assign outy  = y_q;
    assign z_out = z_q;
    assign flag  = f_q;
    assign tula  = tula_q;

endmodule

// File: tb/tb_ula_seq.sv
// Randomized self-checking bench for ula_seq with a behavioural ULA and register model.
// Also exercises the ovf flag when ULA_SEQ_OVF_EN is defined.
module tb_ula_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic [3:0] outx, outy, z_out, outula;
    logic [2:0] tula;
    logic       status, flag, done, err;
`ifdef ULA_SEQ_OVF_EN
    logic       ovf;
`endif

    ula_seq #(.DATA_W(4), .OP_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .operand     (operand),
        .outx        (outx),
        .outy        (outy),
        .tula        (tula),
        .outula      (outula),
        .status      (status),
        .z_out       (z_out),
        .flag        (flag),
        .done        (done),
        .err         (err)
`ifdef ULA_SEQ_OVF_EN
        ,
        .ovf         (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural ULA: arithmetic on signed integers, truncated to 4 bits
    function automatic logic [3:0] ula_res(input logic [2:0] t, input logic [3:0] xa, input logic [3:0] ya);
        int x, y, r;
        x = int'($signed(xa));
        y = int'($signed(ya));
        case (t)
            3'd0:    r = x + y;
            3'd1:    r = x - y;
            3'd2:    r = -y;
            3'd6:    r = x & y;
            3'd7:    r = x ^ y;
            default: r = (x ^ y) ^ 5;
        endcase
        return r[3:0];
    endfunction

    function automatic logic ula_cmp(input logic [2:0] t, input logic [3:0] xa, input logic [3:0] ya);
        int x, y;
        x = int'($signed(xa));
        y = int'($signed(ya));
        case (t)
            3'd3:    return x == y;
            3'd4:    return x > y;
            default: return x < y;
        endcase
    endfunction

    function automatic logic is_cmp_op(input logic [2:0] t);
        return t == 3'd3 || t == 3'd4 || t == 3'd5;
    endfunction

    // status holds its last compare value during non-compare operations
    logic status_hold = 1'b0;
    always_comb begin
        outula = ula_res(tula, outx, outy);
        status = is_cmp_op(tula) ? ula_cmp(tula, outx, outy) : status_hold;
    end
    always @(posedge clk) status_hold <= status;

    logic [3:0] mx, my, mz;
    logic       mf, mo;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".x"}, 32'(outx), 32'(mx));
        check({tag, ".y"}, 32'(outy), 32'(my));
        check({tag, ".z"}, 32'(z_out), 32'(mz));
        check({tag, ".f"}, 32'(flag), 32'(mf));
`ifdef ULA_SEQ_OVF_EN
        check({tag, ".ovf"}, 32'(ovf), 32'(mo));
`endif
    endtask

    task automatic model_reset();
        mx = '0; my = '0; mz = '0; mf = 1'b0; mo = 1'b0;
    endtask

    task automatic model_exec(input logic [3:0] op, input logic [3:0] opd);
        int s;
        if (!op[3]) begin
            if (is_cmp_op(op[2:0])) mf = ula_cmp(op[2:0], mx, my);
            else                    mz = ula_res(op[2:0], mx, my);
            if (op[2:1] == 2'b00) begin
                s  = (op[0] == 1'b0) ? int'($signed(mx)) + int'($signed(my))
                                     : int'($signed(mx)) - int'($signed(my));
                mo = (s > 7) || (s < -8);
            end
        end else begin
            case (op)
                4'b1000: mx = opd;
                4'b1001: my = opd;
                4'b1010: mx = mz;
                4'b1011: my = mz;
                default: ;
            endcase
        end
    endtask

    // Called at a negedge in FETCH; returns at the negedge of the next FETCH cycle
    task automatic run(input logic [3:0] op, input logic [3:0] opd);
        bit alu, ill;
        int lat;
        alu = !op[3];
        ill = op[3] && (op[2:0] > 3'd4);
        lat = alu ? 2 : 1;
        check("ready_fetch", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        opcode      = op;
        operand     = opd;
        @(posedge clk);
        #1;
        instr_valid = 1'($urandom_range(0, 1));
        opcode      = 4'($urandom);
        operand     = 4'($urandom);
        if (alu) check("tula", 32'(tula), 32'(op[2:0]));
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            check("ready_busy", 32'(instr_ready), 32'd0);
            check("done", 32'(done), 32'(c == lat));
            check("err", 32'(err), 32'(ill && c == lat));
        end
        model_exec(op, opd);
        @(negedge clk);
        instr_valid = 1'b0;
        check("ready_next", 32'(instr_ready), 32'd1);
        check("done_low", 32'(done), 32'd0);
        check("err_low", 32'(err), 32'd0);
        check_regs("regs");
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; opcode = '0; operand = '0;
        model_reset();
        #1;
        check("ready_in_rst", 32'(instr_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.tula", 32'(tula), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        check_regs("rst");

        run(4'b1000, 4'd3);
        run(4'b1001, 4'd5);
        run(4'b0000, 4'd0);
        check("add.z", 32'(z_out), 32'h8);
`ifdef ULA_SEQ_OVF_EN
        check("add.ovf", 32'(ovf), 32'd1);
`endif

        run(4'b1000, 4'hE);
        run(4'b1001, 4'd1);
        run(4'b0001, 4'd0);
        check("sub.z", 32'(z_out), 32'hD);
        run(4'b0100, 4'd0);
        check("gt.f", 32'(flag), 32'd0);
        check("gt.z", 32'(z_out), 32'hD);
        run(4'b0101, 4'd0);
        check("lt.f", 32'(flag), 32'd1);

        run(4'b1001, 4'd7);
        run(4'b0010, 4'd0);
        check("neg.z", 32'(z_out), 32'h9);
        run(4'b1010, 4'd0);
        check("mvzx.x", 32'(outx), 32'h9);
        run(4'b0011, 4'd0);
        check("eq.f", 32'(flag), 32'd0);

        run(4'b1110, 4'd6);
        run(4'b1100, 4'd2);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle.ready", 32'(instr_ready), 32'd1);
            check("idle.done", 32'(done), 32'd0);
            check_regs("idle");
        end

        // async reset during EXEC of an ADD
        instr_valid = 1'b1; opcode = 4'b0000; operand = '0;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("arst.ready", 32'(instr_ready), 32'd0);
        check("arst.tula", 32'(tula), 32'd0);
        check("arst.done", 32'(done), 32'd0);
        check_regs("arst");
        @(posedge clk);
        #1;
        check("arst.ready2", 32'(instr_ready), 32'd0);
        check("arst.done2", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst.ready3", 32'(instr_ready), 32'd1);
        check_regs("arst_rel");

        for (int i = 0; i < 200; i++) begin
            run(4'($urandom), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
